regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between three writeback requesters: ALU writeback, load writeback and the debug port. It also provides a hardware clear sequence that zeroes registers 1..REGISTER_NUMBER-1 one per cycle. It sits between the pipeline writeback stage and the register file's data_in / write_select / write_enable inputs. Arbitration is round-robin, and every write reaches the register file through a registered stage.

---
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter (alu/load/dbg) for the register-file write port, plus a hardware clear of regs 1..N-1.
// Latency: handshake -> registered rf write one cycle later; readys are same-cycle grants, all low during clear/done.
module regfile_write_arbiter #(
    parameter int WORD            = 32,
    parameter int REGISTER_NUMBER = 32,
    localparam int AW             = $clog2(REGISTER_NUMBER)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_addr,
    input  logic [WORD-1:0] alu_data,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [AW-1:0]   load_addr,
    input  logic [WORD-1:0] load_data,
    input  logic            dbg_valid,
    output logic            dbg_ready,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [WORD-1:0] dbg_data,
    input  logic            clear_start,
    output logic            clear_busy,
    output logic            clear_done,
    output logic            rf_write_enable,
    output logic [AW-1:0]   rf_write_select,
    output logic [WORD-1:0] rf_data_in
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(REGISTER_NUMBER - 1);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   sel_q, sel_d;
    logic [WORD-1:0] data_q, data_d;
    logic            busy_q, busy_d;
    logic [2:0]      vld;
    logic [2:0]      grant;
    logic [AW-1:0]   w_addr;
    logic [WORD-1:0] w_data;

    // Lowest offset from the pointer wins, so scan offsets from far to near.
    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [2:0] g;
        logic [2:0] s;
        g = '0;
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, p} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (v[s[1:0]]) begin
                g         = '0;
                g[s[1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        vld        = {dbg_valid, load_valid, alu_valid};
        grant      = '0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        sel_d      = sel_q;
        data_d     = data_q;
        busy_d     = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        clear_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = AW'(1);
                end else begin
                    grant = rr_pick(vld, ptr_q);
                    if (grant[0]) begin
                        w_addr = alu_addr;
                        w_data = alu_data;
                        ptr_d  = 2'd1;
                    end else if (grant[1]) begin
                        w_addr = load_addr;
                        w_data = load_data;
                        ptr_d  = 2'd2;
                    end else if (grant[2]) begin
                        w_addr = dbg_addr;
                        w_data = dbg_data;
                        ptr_d  = 2'd0;
                    end
                    // x0 is hardwired: the handshake completes but nothing is written.
                    if (grant != 3'b000 && w_addr != '0) begin
                        we_d   = 1'b1;
                        sel_d  = w_addr;
                        data_d = w_data;
                    end
                end
            end
            S_CLEAR: begin
                // Counter wraps to 0 after the last address; 0 marks the sequence as finished.
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    sel_d  = cnt_q;
                    data_d = '0;
                    cnt_d  = (cnt_q == LAST_ADDR) ? '0 : cnt_q + AW'(1);
                end
            end
            S_DONE: begin
                clear_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign alu_ready       = grant[0] & reset;
    assign load_ready      = grant[1] & reset;
    assign dbg_ready       = grant[2] & reset;
    assign clear_busy      = busy_q;
    assign rf_write_enable = we_q;
    assign rf_write_select = sel_q;
    assign rf_data_in      = data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: a queue-based round-robin model predicts grants and rf writes.
module tb_regfile_write_arbiter;
    localparam int RN = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, load_valid, dbg_valid;
    logic          alu_ready, load_ready, dbg_ready;
    logic [AW-1:0] alu_addr, load_addr, dbg_addr;
    logic [31:0]   alu_data, load_data, dbg_data;
    logic          clear_start, clear_busy, clear_done;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_select;
    logic [31:0]   rf_data_in;

    regfile_write_arbiter #(.WORD(32), .REGISTER_NUMBER(RN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .rf_write_enable(rf_write_enable), .rf_write_select(rf_write_select), .rf_data_in(rf_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          due;
        bit          clr;
    } wr_t;

    wr_t         q[$];
    wr_t         mw;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mptr = 0;
    int          blocked_until = -1;
    int          exp_done = -1;
    int          dbg_wait = 0;
    bit          mon_en = 1'b0;
    bit          pv[3];
    int          pa[3];
    logic [31:0] pd[3];
    logic [31:0] fixd[3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    int          t0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cycle the rf port must match the head of the queue or be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                mw = q.pop_front();
                chk("rf_we", rf_write_enable, 1);
                chk("rf_sel", rf_write_select, mw.addr);
                chk("rf_data", rf_data_in, mw.data);
                chk("clear_busy", clear_busy, mw.clr);
            end else begin
                chk("rf_we_idle", rf_write_enable, 0);
                chk("clear_busy_idle", clear_busy, 0);
            end
            chk("clear_done", clear_done, (cyc == exp_done));
        end
    end

    task automatic new_req(input int i);
        pv[i] = 1'b1;
        pa[i] = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, RN - 1));
        pd[i] = $urandom;
    endtask

    task automatic apply_inputs(input bit clr);
        alu_valid   = pv[0]; alu_addr  = AW'(pa[0]); alu_data  = pd[0];
        load_valid  = pv[1]; load_addr = AW'(pa[1]); load_data = pd[1];
        dbg_valid   = pv[2]; dbg_addr  = AW'(pa[2]); dbg_data  = pd[2];
        clear_start = clr;
    endtask

    // mode 0 random, 1 fixed all-valid, 2 dbg held with alu/load alternating, 3 load only, 4 no new requests
    task automatic drive(input int mode, input bit clr);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!pv[i]) begin
                case (mode)
                    0: if ($urandom % 2 == 1) new_req(i);
                    1: begin pv[i] = 1'b1; pa[i] = i + 1; pd[i] = fixd[i]; end
                    2: if (i == 2 || i == cyc % 2) new_req(i);
                    3: if (i == 1) new_req(i);
                    default: ;
                endcase
            end
        end
        apply_inputs(clr);
    endtask

    task automatic evaluate(input bit clr, input bit stall);
        logic [2:0] exp;
        logic [2:0] act;
        int g;
        int j;
        exp = 3'b000;
        g = -1;
        if (cyc > blocked_until) begin
            if (clr) begin
                for (int a = 1; a < RN; a++) q.push_back('{a, 32'h0, cyc + 1 + a, 1'b1});
                blocked_until = cyc + RN + 1;
                exp_done      = cyc + RN + 1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    j = (mptr + k) % 3;
                    if (pv[j] && g < 0) g = j;
                end
            end
        end
        if (g >= 0) exp[g] = 1'b1;
        act = {dbg_ready, load_ready, alu_ready};
        chk("ready_vec", act, exp);
        if (stall && pv[2]) begin
            if (dbg_ready) begin
                chk("dbg_wait_bound", (dbg_wait < 3), 1);
                dbg_wait = 0;
            end else begin
                dbg_wait++;
                if (dbg_wait >= 3) chk("dbg_starved", dbg_wait, 0);
            end
        end
        if (g >= 0) begin
            if (pa[g] != 0) q.push_back('{pa[g], pd[g], cyc + 1, 1'b0});
            pv[g] = 1'b0;
            mptr  = (g + 1) % 3;
        end
    endtask

    task automatic step(input int mode, input bit clr);
        @(posedge clk);
        #1;
        drive(mode, clr);
        @(negedge clk);
        evaluate(clr, mode == 2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alu_ready"}, alu_ready, 0);
        chk({tag, "_load_ready"}, load_ready, 0);
        chk({tag, "_dbg_ready"}, dbg_ready, 0);
        chk({tag, "_rf_we"}, rf_write_enable, 0);
        chk({tag, "_rf_sel"}, rf_write_select, 0);
        chk({tag, "_rf_data"}, rf_data_in, 0);
        chk({tag, "_busy"}, clear_busy, 0);
        chk({tag, "_done"}, clear_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every requester valid.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin pv[i] = 1'b1; pa[i] = i + 1; pd[i] = fixd[i]; end
        apply_inputs(1'b0);
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        mon_en = 1'b1;

        // Round-robin with all three valid: (1,A),(2,B),(3,C),(1,A)...
        repeat (12) step(1, 1'b0);
        repeat (4) step(4, 1'b0);

        // Write to x0 is accepted but dropped; pointer moves on to load.
        pv[0] = 1'b1; pa[0] = 0; pd[0] = 32'hDEAD_BEEF;
        step(4, 1'b0);
        chk("x0_alu_ready", alu_ready, 1);
        pv[0] = 1'b1; pa[0] = 4; pd[0] = 32'h0000_0044;
        pv[1] = 1'b1; pa[1] = 6; pd[1] = 32'h0000_0066;
        step(4, 1'b0);
        chk("x0_ptr_load", load_ready, 1);
        repeat (3) step(4, 1'b0);

        // Clear while load is waiting; stray clear_start pulses during the sequence are ignored.
        step(3, 1'b0);
        pv[1] = 1'b1; pa[1] = 9; pd[1] = 32'h1234_5678;
        step(3, 1'b1);
        t0 = cyc;
        while (cyc < t0 + RN + 3) step(3, ($urandom % 4 == 0));
        repeat (4) step(3, 1'b0);

        // Reset after the address-10 clear write.
        step(3, 1'b1);
        t0 = cyc;
        while (cyc < t0 + 11) step(3, 1'b0);
        #1;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("midclear");
        q.delete();
        blocked_until = -1;
        exp_done = -1;
        mptr = 0;
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        apply_inputs(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (40) step(0, 1'b0);

        // Dbg held while alu and load alternate.
        dbg_wait = 0;
        repeat (40) step(2, 1'b0);

        // Random traffic with occasional clears.
        repeat (400) step(0, ($urandom % 60 == 0));
        repeat (RN + 6) step(4, 1'b0);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
